// File: rtl/multi_cycle_comparator.sv
// multi_cycle_comparator: chunk-serial magnitude compare, MSB chunk first.
// Unsigned or two's-complement, start/busy/done handshake, one-hot Y.
module multi_cycle_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [2:0]       Y
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    localparam logic [2:0] Y_GT   = 3'b100;
    localparam logic [2:0] Y_EQ   = 3'b010;
    localparam logic [2:0] Y_LT   = 3'b001;
    localparam logic [2:0] Y_NONE = 3'b000;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("multi_cycle_comparator: WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        COMPARE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sign_mask;
    logic [KW-1:0]    k_q;
    logic [2:0]       y_q;
    logic [2:0]       y_nxt;
    logic             done_q;
    logic             load;
    logic             finish;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic             gt;
    logic             lt;
    logic             last;

    // Flip the operand MSB in signed mode so an unsigned compare orders correctly
    always_comb begin
        sign_mask = '0;
        sign_mask[WIDTH-1] = SIGNED;
    end

    // Select chunk k of each latched operand, chunk 0 being the most significant
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                chunk_a = a_q[(N-1-i)*CHUNK +: CHUNK];
                chunk_b = b_q[(N-1-i)*CHUNK +: CHUNK];
            end
        end
    end

    assign gt   = chunk_a > chunk_b;
    assign lt   = chunk_a < chunk_b;
    assign last = (k_q == K_LAST);

    // Next-state and result decode
    always_comb begin
        state_nxt = state;
        y_nxt     = y_q;
        load      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    y_nxt     = Y_NONE;
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                if (gt) begin
                    y_nxt     = Y_GT;
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else if (lt) begin
                    y_nxt     = Y_LT;
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else if (last) begin
                    y_nxt     = Y_EQ;
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch; inputs are ignored outside the accepting cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load) begin
            a_q <= A ^ sign_mask;
            b_q <= B ^ sign_mask;
        end
    end

    // Chunk index walks MSB to LSB while the chunks stay equal
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
        end else if (load) begin
            k_q <= '0;
        end else if (state == COMPARE && !finish) begin
            k_q <= k_q + 1'b1;
        end
    end

    // Result register and one-cycle done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q    <= Y_NONE;
            done_q <= 1'b0;
        end else begin
            y_q    <= y_nxt;
            done_q <= finish;
        end
    end

    assign busy = (state == COMPARE);
    assign done = done_q;
    assign Y    = y_q;

endmodule

// File: tb/tb_multi_cycle_comparator.sv
// Testbench for multi_cycle_comparator: directed handshake steps on a
// CHUNK=4 instance plus a random scoreboard sweep on CHUNK=16 and CHUNK=1.
module tb_multi_cycle_comparator;

    logic        clk;
    logic        rst;
    logic        start_v [3];
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy_w [3];
    logic        done_w [3];
    logic [2:0]  y_w [3];

    int n_checks;
    int n_fails;

    typedef struct {
        logic [2:0] y;
        int         lat;
    } exp_t;

    exp_t exp_q [$];

    multi_cycle_comparator #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .SIGNED(sgn),
        .A(a), .B(b), .busy(busy_w[0]), .done(done_w[0]), .Y(y_w[0])
    );

    multi_cycle_comparator #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .start(start_v[1]), .SIGNED(sgn),
        .A(a), .B(b), .busy(busy_w[1]), .done(done_w[1]), .Y(y_w[1])
    );

    multi_cycle_comparator #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .SIGNED(sgn),
        .A(a), .B(b), .busy(busy_w[2]), .done(done_w[2]), .Y(y_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_y(input logic [15:0] x, input logic [15:0] z,
                                         input logic s);
        int ix;
        int iz;
        ix = s ? {{16{x[15]}}, x} : {16'h0, x};
        iz = s ? {{16{z[15]}}, z} : {16'h0, z};
        if (ix > iz) return 3'b100;
        if (ix < iz) return 3'b001;
        return 3'b010;
    endfunction

    function automatic int ref_lat(input logic [15:0] x, input logic [15:0] z,
                                   input int c);
        logic [15:0] d;
        int p;
        d = x ^ z;
        if (d == 16'h0) return 16 / c;
        p = 0;
        for (int i = 0; i < 16; i++) begin
            if (d[i]) p = i;
        end
        return (15 - p) / c + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int chunk_of(input int d);
        return (d == 0) ? 4 : (d == 1) ? 16 : 1;
    endfunction

    // Drive one request on instance d; returns just after E0
    task automatic issue(input int d, input logic [15:0] x, input logic [15:0] z,
                         input logic s);
        exp_t e;
        e.y   = ref_y(x, z, s);
        e.lat = ref_lat(x, z, chunk_of(d));
        exp_q.push_back(e);
        a = x;
        b = z;
        sgn = s;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        chk("busy_after_start", 32'(busy_w[d]), 32'd1);
        chk("y_cleared", 32'(y_w[d]), 32'd0);
    endtask

    // Wait for done (bounded), then pop and compare result and latency
    task automatic finish_cmp(input int d, input int edges0, input string tag,
                              output int busy_cnt);
        exp_t e;
        int n;
        logic got;
        n = edges0;
        busy_cnt = edges0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (done_w[d]) got = 1'b1;
            else if (busy_w[d]) busy_cnt++;
        end
        e = exp_q.pop_front();
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_y"}, 32'(y_w[d]), 32'(e.y));
            chk({tag, "_latency"}, 32'(n), 32'(e.lat));
            chk({tag, "_busy_low_in_done"}, 32'(busy_w[d]), 32'd0);
        end
    endtask

    initial begin
        int bc;
        int seen;
        logic [15:0] x;
        logic [15:0] z;
        logic s;
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        sgn = 1'b0;
        a = '0;
        b = '0;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_busy", 32'(busy_w[i]), 32'd0);
            chk("reset_done", 32'(done_w[i]), 32'd0);
            chk("reset_y", 32'(y_w[i]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(0, 16'h1234, 16'h1234, 1'b0);
        finish_cmp(0, 0, "equal", bc);
        chk("equal_busy_cycles", 32'(bc + 1), 32'd4);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done_w[0]), 32'd0);
        chk("y_held", 32'(y_w[0]), 32'b010);

        issue(0, 16'h8000, 16'h7FFF, 1'b0);
        finish_cmp(0, 0, "top_unsigned", bc);
        issue(0, 16'h8000, 16'h7FFF, 1'b1);
        chk("done_low_after_b2b", 32'(done_w[0]), 32'd0);
        finish_cmp(0, 0, "top_signed", bc);

        issue(0, 16'h12F4, 16'h1234, 1'b0);
        finish_cmp(0, 0, "mid_exit", bc);
        issue(0, 16'hFFFF, 16'hFFFE, 1'b1);
        finish_cmp(0, 0, "neg_pair", bc);

        issue(0, 16'h1234, 16'h1234, 1'b0);
        start_v[0] = 1'b1;
        a = 16'h0000;
        b = 16'hFFFF;
        sgn = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        a = 16'hFFFF;
        b = 16'h0000;
        @(posedge clk);
        #1;
        finish_cmp(0, 2, "start_ignored", bc);

        issue(0, 16'h0001, 16'h0002, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_front());
        chk("rst_mid_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_mid_done", 32'(done_w[0]), 32'd0);
        chk("rst_mid_y", 32'(y_w[0]), 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done_w[0] || busy_w[0]) seen++;
        end
        chk("no_done_after_rst", 32'(seen), 32'd0);
        issue(0, 16'h0001, 16'h0002, 1'b0);
        finish_cmp(0, 0, "after_rst", bc);

        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom);
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: z = 16'($urandom);
                1: z = x;
                2: z = x ^ (16'h1 << $urandom_range(0, 15));
                default: z = x ^ (16'($urandom) >> $urandom_range(0, 15));
            endcase
            issue(1, x, z, s);
            finish_cmp(1, 0, "sweep_c16", bc);
            issue(2, x, z, s);
            finish_cmp(2, 0, "sweep_c1", bc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
